// File: rtl/multiplicador_booth_pkg.sv
// Shared types and latency helper for the Booth multiplier.
// Define MULTIPLICADOR_RADIX4_EN to select radix-4 recoding; radix-2 otherwise.
package multiplicador_pkg;

    typedef enum logic {
        OCIOSO,
        CALCULA
    } estado_e;

    typedef enum logic [2:0] {
        ZERO,
        MAIS_M,
        MENOS_M,
        MAIS_2M,
        MENOS_2M
    } digito_e;

`ifdef MULTIPLICADOR_RADIX4_EN
    localparam int unsigned BOOTH_PASSO = 2;
`else
    localparam int unsigned BOOTH_PASSO = 1;
`endif

    // Number of multiplier bits inspected per step (pair or triplet).
    localparam int unsigned GRUPO_W = BOOTH_PASSO + 1;

    function automatic int unsigned booth_n(input int unsigned width);
        return width + BOOTH_PASSO;
    endfunction

    function automatic int unsigned booth_latencia(input int unsigned width);
        return (width + BOOTH_PASSO) / BOOTH_PASSO;
    endfunction

endpackage

// File: rtl/multiplicador_booth_recodificador.sv
// Combinational Booth digit selector: maps the low multiplier bits to a digit code.
// Radix-4 triplet decoding when MULTIPLICADOR_RADIX4_EN is defined, radix-2 pair otherwise.
module booth_recodificador
    import multiplicador_pkg::*;
(
    input  logic [GRUPO_W-1:0] grupo_i,
    output digito_e            digito_o
);

    always_comb begin
        digito_o = ZERO;
`ifdef MULTIPLICADOR_RADIX4_EN
        case (grupo_i)
            3'b001, 3'b010: digito_o = MAIS_M;
            3'b011:         digito_o = MAIS_2M;
            3'b100:         digito_o = MENOS_2M;
            3'b101, 3'b110: digito_o = MENOS_M;
            default:        digito_o = ZERO;
        endcase
`else
        case (grupo_i)
            2'b01:   digito_o = MAIS_M;
            2'b10:   digito_o = MENOS_M;
            default: digito_o = ZERO;
        endcase
`endif
    end

endmodule

// File: rtl/multiplicador_booth.sv
// Sequential signed/unsigned Booth multiplier with start/ocupado/fim handshake.
// MULTIPLICADOR_RADIX4_EN selects radix-4 (shorter latency); default build is radix-2.
module multiplicador_booth
    import multiplicador_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sinal,
    input  logic [WIDTH-1:0] operando1,
    input  logic [WIDTH-1:0] operando2,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ocupado,
    output logic             fim
);

    localparam int unsigned N     = booth_n(WIDTH);
    localparam int unsigned L     = booth_latencia(WIDTH);
    localparam int unsigned PASSO = BOOTH_PASSO;
    localparam int unsigned AW    = 2 * N + 1;
    localparam int unsigned SW    = N + PASSO;
    localparam int unsigned CW    = $clog2(L);

    estado_e          estado_q, estado_d;
    logic [CW-1:0]    cont_q, cont_d;
    logic [N-1:0]     m_q, m_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             fim_q, fim_d;

    digito_e          digito;
    logic [SW-1:0]    a_ext, m_ext, parcela, soma;
    logic [AW-1:0]    passo;

    booth_recodificador u_recodificador (
        .grupo_i  (acc_q[GRUPO_W-1:0]),
        .digito_o (digito)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
            cont_q   <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            fim_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            fim_q    <= fim_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO:  if (start) estado_d = CALCULA;
            CALCULA: if (cont_q == '0) estado_d = OCIOSO;
        endcase
    end

    always_comb begin
        ocupado = (estado_q == CALCULA);
        fim     = fim_q;
        hi      = hi_q;
        lo      = lo_q;
    end

    // Accumulator layout {A[N], P[N], appended bit}; A is widened by PASSO bits so
    // the add/subtract is exact and the shift takes the sum directly.
    always_comb begin
        a_ext = {{PASSO{acc_q[AW-1]}}, acc_q[AW-1 -: N]};
        m_ext = {{PASSO{m_q[N-1]}}, m_q};
        parcela = '0;
        case (digito)
            MAIS_M:   parcela = m_ext;
            MENOS_M:  parcela = -m_ext;
            MAIS_2M:  parcela = {m_ext[SW-2:0], 1'b0};
            MENOS_2M: parcela = -{m_ext[SW-2:0], 1'b0};
            default:  parcela = '0;
        endcase
        soma  = a_ext + parcela;
        passo = {soma, acc_q[N:PASSO]};
    end

    always_comb begin
        m_d    = m_q;
        acc_d  = acc_q;
        cont_d = cont_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        fim_d  = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (start) begin
                    m_d    = {{PASSO{sinal & operando1[WIDTH-1]}}, operando1};
                    acc_d  = {{N{1'b0}}, {PASSO{sinal & operando2[WIDTH-1]}}, operando2, 1'b0};
                    cont_d = CW'(L - 1);
                end
            end
            CALCULA: begin
                acc_d  = passo;
                cont_d = cont_q - 1'b1;
                if (cont_q == '0) begin
                    hi_d  = acc_d[2*WIDTH:WIDTH+1];
                    lo_d  = acc_d[WIDTH:1];
                    fim_d = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_multiplicador_booth.sv
// Directed self-checking bench for multiplicador_booth (WIDTH=32 and WIDTH=8 instances).
module tb_multiplicador_booth;

`ifdef MULTIPLICADOR_RADIX4_EN
    localparam int L32 = 17;
    localparam int L8  = 5;
`else
    localparam int L32 = 33;
    localparam int L8  = 9;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start, sinal;
    logic [31:0] op1, op2, hi, lo;
    logic        ocupado, fim;
    logic        start8, sinal8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        ocupado8, fim8;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multiplicador_booth #(.WIDTH(32)) dut (
        .clock(clk), .reset(reset), .start(start), .sinal(sinal),
        .operando1(op1), .operando2(op2), .hi(hi), .lo(lo),
        .ocupado(ocupado), .fim(fim)
    );

    multiplicador_booth #(.WIDTH(8)) dut8 (
        .clock(clk), .reset(reset), .start(start8), .sinal(sinal8),
        .operando1(a8), .operando2(b8), .hi(hi8), .lo(lo8),
        .ocupado(ocupado8), .fim(fim8)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] rhi, output logic [31:0] rlo, output int lat);
        bit seen = 1'b0;
        op1 = a; op2 = b; sinal = s; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ocupado_after_accept", {63'd0, ocupado}, 64'd1);
        lat = 0;
        for (int n = 1; n <= 200 && !seen; n++) begin
            tick();
            if (fim) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        chk("fim_seen", {63'd0, seen}, 64'd1);
        chk("ocupado_at_fim", {63'd0, ocupado}, 64'd0);
        rhi = hi;
        rlo = lo;
        tick();
        chk("fim_one_cycle", {63'd0, fim}, 64'd0);
        chk("result_held", {hi, lo}, {rhi, rlo});
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [7:0] rhi, output logic [7:0] rlo, output int lat);
        bit seen = 1'b0;
        a8 = a; b8 = b; sinal8 = s; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100 && !seen; n++) begin
            tick();
            if (fim8) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        chk("fim8_seen", {63'd0, seen}, 64'd1);
        rhi = hi8;
        rlo = lo8;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] exp_hi;
        logic [7:0] exp_lo;
    } vec8_t;

    vec_t  tbl[9];
    vec8_t tbl8[3];

    initial begin
        logic [31:0] rhi, rlo, lo1, lo2;
        logic [7:0]  rhi8, rlo8;
        int          lat, nf, f1, f2;

        tbl[0] = '{32'hFFFFFFF9, 32'h00000003, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001};
        tbl[3] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
        tbl[4] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 32'hC0000000, 32'h80000000};
        tbl[5] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'h3FFFFFFF, 32'h00000001};
        tbl[6] = '{32'h80000000, 32'h00000002, 1'b0, 32'h00000001, 32'h00000000};
        tbl[7] = '{32'h00001234, 32'h00005678, 1'b0, 32'h00000000, 32'h06260060};
        tbl[8] = '{32'h00000000, 32'hDEADBEEF, 1'b0, 32'h00000000, 32'h00000000};

        tbl8[0] = '{8'h80, 8'h80, 1'b1, 8'h40, 8'h00};
        tbl8[1] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 8'h01};
        tbl8[2] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 8'h01};

        reset = 1'b1; start = 1'b0; sinal = 1'b0; op1 = '0; op2 = '0;
        start8 = 1'b0; sinal8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_hi_lo", {hi, lo}, 64'd0);
        chk("reset_ocupado", {63'd0, ocupado}, 64'd0);
        chk("reset_fim", {63'd0, fim}, 64'd0);
        chk("reset8_hi_lo", {48'd0, hi8, lo8}, 64'd0);

        for (int i = 0; i < 9; i++) begin
            run32(tbl[i].a, tbl[i].b, tbl[i].s, rhi, rlo, lat);
            chk($sformatf("vec%0d_hi", i), {32'd0, rhi}, {32'd0, tbl[i].exp_hi});
            chk($sformatf("vec%0d_lo", i), {32'd0, rlo}, {32'd0, tbl[i].exp_lo});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(L32));
        end

        // Second start while busy must be ignored.
        op1 = 32'd5; op2 = 32'd6; sinal = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        nf = 0; f1 = 0; rhi = '0; rlo = '0;
        for (int n = 1; n <= L32 + 6; n++) begin
            tick();
            if (fim) begin
                nf++; f1 = n; rhi = hi; rlo = lo;
            end
            if (n == 2) begin
                op1 = 32'd9; op2 = 32'd9; start = 1'b1;
            end
            if (n == 3) start = 1'b0;
        end
        chk("busy_start_fim_count", 64'(nf), 64'd1);
        chk("busy_start_latency", 64'(f1), 64'(L32));
        chk("busy_start_result", {rhi, rlo}, 64'h0000_0000_0000_001E);

        // Reset mid-operation aborts without fim.
        op1 = 32'h1234; op2 = 32'h5678; sinal = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_hi_lo", {hi, lo}, 64'd0);
        chk("abort_ocupado", {63'd0, ocupado}, 64'd0);
        chk("abort_fim", {63'd0, fim}, 64'd0);
        nf = 0;
        for (int n = 1; n <= L32 + 5; n++) begin
            tick();
            if (fim) nf++;
        end
        chk("abort_no_fim", 64'(nf), 64'd0);
        run32(32'h1234, 32'h5678, 1'b0, rhi, rlo, lat);
        chk("after_abort_result", {rhi, rlo}, 64'h0000_0000_0626_0060);
        chk("after_abort_latency", 64'(lat), 64'(L32));

        // Back-to-back: start held through the fim cycle.
        op1 = 32'd2; op2 = 32'd3; sinal = 1'b0; start = 1'b1;
        tick();
        op1 = 32'd4; op2 = 32'd5;
        nf = 0; f1 = 0; f2 = 0; lo1 = '0; lo2 = '0;
        for (int n = 1; n <= 2 * L32 + 6; n++) begin
            tick();
            if (fim) begin
                nf++;
                if (nf == 1) begin
                    f1 = n; lo1 = lo;
                end else if (nf == 2) begin
                    f2 = n; lo2 = lo;
                end
            end
            if (n == L32 + 1) start = 1'b0;
        end
        chk("b2b_fim_count", 64'(nf), 64'd2);
        chk("b2b_first_fim", 64'(f1), 64'(L32));
        chk("b2b_second_fim", 64'(f2), 64'(2 * L32 + 1));
        chk("b2b_first_lo", {32'd0, lo1}, 64'h6);
        chk("b2b_second_lo", {32'd0, lo2}, 64'h14);

        for (int i = 0; i < 3; i++) begin
            run8(tbl8[i].a, tbl8[i].b, tbl8[i].s, rhi8, rlo8, lat);
            chk($sformatf("w8_vec%0d_result", i), {48'd0, rhi8, rlo8},
                {48'd0, tbl8[i].exp_hi, tbl8[i].exp_lo});
            chk($sformatf("w8_vec%0d_latency", i), 64'(lat), 64'(L8));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
